ascon_spi_regfile: RTL and testbench
====================================

# ascon_spi_regfile

Clock-domain SPI subnode and register bank for the Ascon accelerator, the parametrised successor of the current SCK-clocked SPI subnode. It oversamples SCK/CSB/MOSI in the `clk` domain and exposes a configurable number of input registers of configurable width. It also provides a control register with a start/busy handshake, a sticky status register, and read-only access to the five 64-bit Ascon state words. It sits between the top-level `uio` pins and the `ascon` core.

## Interface
- `NUM_REGS`, 3: number of writable data registers, 1..16.
- `REG_W`, 128: data register width in bits, a multiple of 8, 8..256.
- `SYNC_STAGES`, 2: synchronizer depth on SCK/CSB/MOSI, ≥2.

Ports:
- `clk` in 1: system clock; must be ≥4× SCK frequency.
- `rst` in 1: asynchronous, active-high reset.
- `sck_i` in 1: SPI clock, mode 0.
- `csb_i` in 1: chip select, active low.
- `mosi_i` in 1: serial data in.
- `miso_o` out 1: serial data out.
- `miso_oe_o` out 1: MISO output enable.
- `regs_o` out NUM_REGS*REG_W: data registers; reg k occupies bits [k*REG_W +: REG_W].
- `mode_o` out 3: operation mode to the core.
- `start_o` out 1: single-cycle start pulse.
- `busy_i` in 1: core busy.
- `done_i` in 1: core completion pulse.
- `state_i` in 320: Ascon state {S4,S3,S2,S1,S0}, S0 in bits [63:0].

## Operation
- Transaction: CSB falls, then a command byte MSB first. Bit7 = write (1) / read (0); bits[6:0] = address. Data bytes follow, MSB first.
- Address map:
  - 0x00..NUM_REGS-1: data regs, R/W, REG_W bits each.
  - 0x10: control, 8 bits. Bits[2:0] = mode; bit7 = start.
  - 0x11: status, 8 bits, RO. Bit0 busy_i, bit1 done_sticky, bit2 err.
  - 0x20..0x24: S0..S4, 64 bits each, RO.
  - Other addresses: invalid.
- FSM states: IDLE, CMD, WDATA, RDATA, SKIP.
  - IDLE→CMD on synchronized CSB falling edge.
  - CMD→WDATA, RDATA or SKIP after the 8th sampled bit. SKIP is taken for invalid addresses and for writes to RO addresses.
  - Any state→IDLE on CSB high.
- Writes:
  - Bits shift into a REG_W shadow register.
  - The target is committed only when its full width has been received. A partial word aborted by CSB is discarded and the target is unchanged.
- Reads:
  - Target is snapshotted in the CMD→RDATA cycle.
  - Shifted out MSB first. MISO updates on the synchronized SCK falling edge. The first bit is presented before the first data SCK rise.
  - A status read clears done_sticky and err at snapshot time.
- Control write:
  - mode_o latched.
  - If bit7=1 and busy_i=0: start_o pulses for 1 cycle.
  - If bit7=1 and busy_i=1: no pulse, err set.
- done_i sets done_sticky. A set from done_i wins over a simultaneous clear.
- miso_o drives 0 in IDLE and SKIP. miso_oe_o = synchronized ~CSB.
- Reset: regs_o, mode_o, start_o, miso_o, miso_oe_o, done_sticky, err, shadow and counters = 0; FSM = IDLE. Reset mid-transaction aborts it with no commit.

## Timing
- Input path: SYNC_STAGES flops + 1 edge-detect flop. A bit is sampled SYNC_STAGES+1 clk cycles after the SCK rise.
- Write commit: regs_o/mode_o update on the clk edge after the last bit is sampled. start_o is asserted in that same cycle.
- MISO changes SYNC_STAGES+1 clk cycles after the SCK fall. This is valid for the next rise given clk ≥4× SCK.
- The bit counter is wide enough for max(REG_W,64) and is reset on every state change.

## Configuration
- `ASCON_SPI_BURST_EN` defined:
  - After a word completes, the address increments and the transaction continues in the same direction.
  - Incrementing past the last valid address of a region enters SKIP.
- Not defined: extra bytes after one word go to SKIP; they are ignored, and MISO reads 0.

## Structure
- Package `ascon_spi_pkg`:
  - address constants (ADDR_CTRL, ADDR_STATUS, ADDR_STATE_BASE);
  - command bit positions;
  - FSM state enum;
  - status bit indices.
- Sub-module `ascon_spi_sync`: N-stage synchronizer plus rise/fall edge detect, instantiated once per input.

## Test plan
- Reset, then write 0x80 + 16 bytes 0x00..0x0F (NUM_REGS=3, REG_W=128) → regs_o reg0 = 0x000102…0F; reg1 and reg2 = 0.
- Write reg1 and raise CSB after 5 data bytes → reg1 unchanged (0). A following full write of reg1 succeeds.
- Write 0x90 + byte 0x83 with busy_i=0 → mode_o=3 and exactly one start_o pulse. Repeat with busy_i=1 → no pulse; status read returns 0x05; a second status read returns 0x01.
- Drive state_i S2 = 0xDEADBEEF01234567 and read 0x22 → MISO returns those 8 bytes MSB first.
- Burst write 0x80 + 32 bytes: with `ASCON_SPI_BURST_EN`, reg0 and reg1 are both written. Without it, only reg0 is written.
- Assert rst mid-read → miso_o=0, FSM=IDLE. The next transaction after deassert works normally.

Source files
------------

// File: rtl/ascon_spi_pkg.sv
// Shared constants and types for the Ascon SPI register bank:
// address map, command byte layout, FSM states and status bit positions.
package ascon_spi_pkg;

    localparam logic [6:0] ADDR_CTRL       = 7'h10;
    localparam logic [6:0] ADDR_STATUS     = 7'h11;
    localparam logic [6:0] ADDR_STATE_BASE = 7'h20;
    localparam int         STATE_WORDS     = 5;

    localparam int CMD_WR_BIT   = 7;
    localparam int CMD_ADDR_MSB = 6;

    localparam int CTRL_START_BIT = 7;
    localparam int CTRL_MODE_W    = 3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_SKIP
    } spi_state_t;

    function automatic logic is_state_addr(input logic [6:0] a);
        return (a >= ADDR_STATE_BASE) && (a < ADDR_STATE_BASE + 7'(STATE_WORDS));
    endfunction

endpackage

// File: rtl/ascon_spi_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, followed by a
// single edge-detect flop that yields one-cycle rise/fall pulses.
module ascon_spi_sync #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // Shift the raw pin through the synchronizer and remember the last settled level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/ascon_spi_regfile.sv
// SPI subnode (mode 0, clk-domain oversampled) with data registers, a
// control/status pair and read-only access to the Ascon state words.
// Optional feature: define ASCON_SPI_BURST_EN to let a transaction run on
// into the next address of the same region after each completed word.
module ascon_spi_regfile
    import ascon_spi_pkg::*;
#(
    parameter int NUM_REGS    = 3,
    parameter int REG_W       = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sck_i,
    input  logic                      csb_i,
    input  logic                      mosi_i,
    output logic                      miso_o,
    output logic                      miso_oe_o,
    output logic [NUM_REGS*REG_W-1:0] regs_o,
    output logic [2:0]                mode_o,
    output logic                      start_o,
    input  logic                      busy_i,
    input  logic                      done_i,
    input  logic [319:0]              state_i
);

`ifdef ASCON_SPI_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    localparam int DATA_W = (REG_W > 64) ? REG_W : 64;
    localparam int CNT_W  = $clog2(DATA_W) + 1;

    logic sck_q, sck_rise, sck_fall;
    logic csb_q, csb_rise, csb_fall;
    logic mosi_q, mosi_rise, mosi_fall;

    ascon_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .d(sck_i), .q(sck_q), .rise(sck_rise), .fall(sck_fall)
    );
    ascon_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csb (
        .clk(clk), .rst(rst), .d(csb_i), .q(csb_q), .rise(csb_rise), .fall(csb_fall)
    );
    ascon_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi_i), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
    );

    spi_state_t        state, state_next;
    logic [CNT_W-1:0]  bit_cnt, word_len;
    logic [REG_W-1:0]  shadow, shadow_in;
    logic [DATA_W-1:0] tx_sreg, rd_word;
    logic [6:0]        addr, addr_inc, cmd_addr, rd_addr;
    logic              cmd_wr, cmd_done, word_done, snap_en, miso_q;
    logic [REG_W-1:0]  regs [NUM_REGS];
    logic [2:0]        mode_q;
    logic              start_q, done_sticky, err;
    logic [7:0]        status_byte;
    logic              unused_sigs;

    function automatic logic is_data_addr(input logic [6:0] a);
        return a < 7'(NUM_REGS);
    endfunction

    function automatic logic is_readable(input logic [6:0] a);
        return is_data_addr(a) || (a == ADDR_CTRL) || (a == ADDR_STATUS) || is_state_addr(a);
    endfunction

    function automatic logic is_writable(input logic [6:0] a);
        return is_data_addr(a) || (a == ADDR_CTRL);
    endfunction

    function automatic logic [CNT_W-1:0] addr_len(input logic [6:0] a);
        if (is_data_addr(a))  return CNT_W'(REG_W);
        if (is_state_addr(a)) return CNT_W'(64);
        return CNT_W'(8);
    endfunction

    assign shadow_in = {shadow[REG_W-2:0], mosi_q};
    assign cmd_wr    = shadow_in[CMD_WR_BIT];
    assign cmd_addr  = shadow_in[CMD_ADDR_MSB:0];
    assign cmd_done  = (state == ST_CMD) && sck_rise && (bit_cnt == CNT_W'(7));
    assign word_done = sck_rise && (bit_cnt == word_len - CNT_W'(1));
    assign addr_inc  = addr + 7'd1;
    assign rd_addr   = (state == ST_CMD) ? cmd_addr : addr_inc;
    assign snap_en   = (state_next == ST_RDATA) && (cmd_done || ((state == ST_RDATA) && word_done));
    assign unused_sigs = ^{sck_q, csb_rise, mosi_rise, mosi_fall, shadow[REG_W-1]};

    // Next-state logic: CSB high always wins, otherwise advance on command/word boundaries
    always_comb begin
        state_next = state;
        if (csb_q) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (csb_fall) state_next = ST_CMD;
                ST_CMD: begin
                    if (cmd_done) begin
                        if (cmd_wr) state_next = is_writable(cmd_addr) ? ST_WDATA : ST_SKIP;
                        else        state_next = is_readable(cmd_addr) ? ST_RDATA : ST_SKIP;
                    end
                end
                ST_WDATA: begin
                    if (word_done)
                        state_next = (BURST_EN && is_data_addr(addr) && is_data_addr(addr_inc))
                                     ? ST_WDATA : ST_SKIP;
                end
                ST_RDATA: begin
                    if (word_done)
                        state_next = (BURST_EN &&
                                      ((is_data_addr(addr) && is_data_addr(addr_inc)) ||
                                       (is_state_addr(addr) && is_state_addr(addr_inc))))
                                     ? ST_RDATA : ST_SKIP;
                end
                default:  state_next = state;
            endcase
        end
    end

    // Readable value for the address being snapshotted, left-aligned in the shift register
    always_comb begin
        status_byte            = '0;
        status_byte[STAT_BUSY] = busy_i;
        status_byte[STAT_DONE] = done_sticky;
        status_byte[STAT_ERR]  = err;
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == 7'(k)) rd_word[DATA_W-1 -: REG_W] = regs[k];
        end
        if (rd_addr == ADDR_CTRL)   rd_word[DATA_W-1 -: 8] = {5'b0, mode_q};
        if (rd_addr == ADDR_STATUS) rd_word[DATA_W-1 -: 8] = status_byte;
        for (int i = 0; i < STATE_WORDS; i++) begin
            if (rd_addr == ADDR_STATE_BASE + 7'(i)) rd_word[DATA_W-1 -: 64] = state_i[i*64 +: 64];
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Datapath: bit counting, shifting, commits, read snapshots and sticky status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            word_len    <= CNT_W'(8);
            shadow      <= '0;
            tx_sreg     <= '0;
            miso_q      <= 1'b0;
            addr        <= '0;
            mode_q      <= '0;
            start_q     <= 1'b0;
            done_sticky <= 1'b0;
            err         <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else begin
            start_q <= 1'b0;

            if (state != state_next)
                bit_cnt <= '0;
            else if (sck_rise && (state == ST_CMD))
                bit_cnt <= bit_cnt + CNT_W'(1);
            else if (sck_rise && ((state == ST_WDATA) || (state == ST_RDATA)))
                bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);

            if (sck_rise && ((state == ST_CMD) || (state == ST_WDATA)))
                shadow <= shadow_in;

            if (cmd_done) begin
                addr     <= cmd_addr;
                word_len <= addr_len(cmd_addr);
            end

            if ((state == ST_WDATA) && word_done) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (addr == 7'(k)) regs[k] <= shadow_in;
                end
                if (addr == ADDR_CTRL) begin
                    mode_q <= shadow_in[CTRL_MODE_W-1:0];
                    if (shadow_in[CTRL_START_BIT]) begin
                        if (busy_i) err     <= 1'b1;
                        else        start_q <= 1'b1;
                    end
                end
                if (BURST_EN) addr <= addr_inc;
            end

            if ((state == ST_RDATA) && word_done && BURST_EN)
                addr <= addr_inc;

            if (snap_en) begin
                tx_sreg <= rd_word;
                miso_q  <= rd_word[DATA_W-1];
                if (rd_addr == ADDR_STATUS) begin
                    done_sticky <= 1'b0;
                    err         <= 1'b0;
                end
            end else if ((state == ST_RDATA) && sck_fall && (bit_cnt != '0)) begin
                tx_sreg <= tx_sreg << 1;
                miso_q  <= tx_sreg[DATA_W-2];
            end else if (state_next != ST_RDATA) begin
                miso_q <= 1'b0;
            end

            if (done_i) done_sticky <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_o[g*REG_W +: REG_W] = regs[g];
    end

    assign mode_o    = mode_q;
    assign start_o   = start_q;
    assign miso_o    = (state == ST_RDATA) ? miso_q : 1'b0;
    assign miso_oe_o = ~csb_q;

endmodule

// File: tb/tb_ascon_spi_regfile.sv
// Scoreboard testbench for ascon_spi_regfile: drives SPI mode-0 transactions,
// queues expected register/MISO values and compares them as outputs appear.
`timescale 1ns/1ps
module tb_ascon_spi_regfile;
    import ascon_spi_pkg::*;

    localparam int NUM_REGS    = 3;
    localparam int REG_W       = 128;
    localparam int SYNC_STAGES = 2;
    localparam int RW          = NUM_REGS * REG_W;

    logic           clk = 1'b0, rst = 1'b1;
    logic           sck = 1'b0, csb = 1'b1, mosi = 1'b0;
    logic           busy = 1'b0, done = 1'b0;
    logic           miso, miso_oe, start;
    logic [RW-1:0]  regs;
    logic [2:0]     mode;
    logic [319:0]   state_in = '0;

    int n_cmp = 0, n_bad = 0, start_cnt = 0;
    logic [7:0]     tx_bytes[$];
    logic [RW-1:0]  exp_q[$];
    string          tag_q[$];
    logic [REG_W-1:0] m_regs [NUM_REGS];

    ascon_spi_regfile #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .sck_i(sck), .csb_i(csb), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe), .regs_o(regs), .mode_o(mode),
        .start_o(start), .busy_i(busy), .done_i(done), .state_i(state_in)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (start) start_cnt++;

    task automatic checkOutput(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expectValue(input string tag, input logic [RW-1:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic popCheck(input logic [RW-1:0] obs);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL scoreboard_underflow: got %0h expected nothing queued", obs);
        end else begin
            checkOutput(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    function automatic logic [RW-1:0] packRegs();
        logic [RW-1:0] v = '0;
        for (int k = 0; k < NUM_REGS; k++) v[k*REG_W +: REG_W] = m_regs[k];
        return v;
    endfunction

    // One full SPI transaction from tx_bytes; received data bytes go through the scoreboard
    task automatic applyStimulus(input bit check_rx);
        logic [7:0] rx;
        csb = 1'b0;
        #100;
        for (int i = 0; i < tx_bytes.size(); i++) begin
            rx = '0;
            for (int b = 7; b >= 0; b--) begin
                mosi = tx_bytes[i][b];
                #50;
                sck = 1'b1;
                rx  = {rx[6:0], miso};
                #50;
                sck = 1'b0;
            end
            if (check_rx && i > 0) popCheck(RW'(rx));
        end
        #50;
        csb  = 1'b1;
        mosi = 1'b0;
        #300;
    endtask

    task automatic loadBytes(input logic [7:0] cmd, input int n, input logic [7:0] first, input bit incr);
        tx_bytes.delete();
        tx_bytes.push_back(cmd);
        for (int i = 0; i < n; i++) tx_bytes.push_back(incr ? first + 8'(i) : first);
    endtask

    function automatic logic [REG_W-1:0] seqWord(input logic [7:0] first);
        logic [REG_W-1:0] w = '0;
        for (int i = 0; i < REG_W/8; i++) w = {w[REG_W-9:0], first + 8'(i)};
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [63:0] s [STATE_WORDS];
        int sc;
        s[0] = 64'h0F1E2D3C4B5A6978;
        s[1] = 64'hCAFEBABE00C0FFEE;
        s[2] = 64'hDEADBEEF01234567;
        s[3] = 64'h1122334455667788;
        s[4] = 64'hA5A55A5AF0F00F0F;
        state_in = {s[4], s[3], s[2], s[1], s[0]};
        for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;

        repeat (3) @(negedge clk);
        expectValue("reset_regs", '0);       popCheck(regs);
        expectValue("reset_mode", '0);       popCheck(RW'(mode));
        expectValue("reset_start", '0);      popCheck(RW'(start));
        expectValue("reset_miso", '0);       popCheck(RW'(miso));
        expectValue("reset_miso_oe", '0);    popCheck(RW'(miso_oe));
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Full write of reg0, then read it back
        loadBytes(8'h80, 16, 8'h00, 1'b1);
        m_regs[0] = seqWord(8'h00);
        expectValue("write_reg0", packRegs());
        applyStimulus(1'b0);
        popCheck(regs);
        loadBytes(8'h00, 16, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) expectValue($sformatf("read_reg0_b%0d", i), RW'(i));
        applyStimulus(1'b1);

        // Aborted partial write leaves reg1 alone; a full one lands
        loadBytes(8'h81, 5, 8'hFF, 1'b0);
        expectValue("partial_write_discarded", packRegs());
        applyStimulus(1'b0);
        popCheck(regs);
        loadBytes(8'h81, 16, 8'hA0, 1'b1);
        m_regs[1] = seqWord(8'hA0);
        expectValue("write_reg1", packRegs());
        applyStimulus(1'b0);
        popCheck(regs);

        // Control writes: start accepted when idle, refused with err when busy
        sc = start_cnt;
        busy = 1'b0;
        loadBytes(8'h90, 1, 8'h83, 1'b0);
        expectValue("ctrl_mode", RW'(3));
        expectValue("start_pulse_once", RW'(sc + 1));
        applyStimulus(1'b0);
        popCheck(RW'(mode));
        popCheck(RW'(start_cnt));
        busy = 1'b1;
        loadBytes(8'h90, 1, 8'h83, 1'b0);
        expectValue("start_blocked_busy", RW'(sc + 1));
        applyStimulus(1'b0);
        popCheck(RW'(start_cnt));
        loadBytes(8'h11, 1, 8'h00, 1'b0);
        expectValue("status_busy_err", RW'(8'h05));
        applyStimulus(1'b1);
        loadBytes(8'h11, 1, 8'h00, 1'b0);
        expectValue("status_err_cleared", RW'(8'h01));
        applyStimulus(1'b1);
        busy = 1'b0;

        // done_i sets the sticky bit, which a status read then clears
        @(negedge clk); done = 1'b1;
        @(negedge clk); done = 1'b0;
        loadBytes(8'h11, 1, 8'h00, 1'b0);
        expectValue("status_done_sticky", RW'(8'h02));
        applyStimulus(1'b1);
        loadBytes(8'h11, 1, 8'h00, 1'b0);
        expectValue("status_done_cleared", RW'(8'h00));
        applyStimulus(1'b1);
        loadBytes(8'h10, 1, 8'h00, 1'b0);
        expectValue("read_ctrl", RW'(8'h03));
        applyStimulus(1'b1);

        // State word S2 read MSB first, plus one extra byte past the word
        loadBytes(8'h22, 9, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) expectValue($sformatf("read_s2_b%0d", i), RW'(s[2][63-8*i -: 8]));
`ifdef ASCON_SPI_BURST_EN
        expectValue("read_s2_extra", RW'(s[3][63:56]));
`else
        expectValue("read_s2_extra", RW'(8'h00));
`endif
        applyStimulus(1'b1);

        // Invalid addresses: reads return zero, writes change nothing
        loadBytes(8'h7F, 2, 8'h00, 1'b0);
        expectValue("read_invalid_b0", '0);
        expectValue("read_invalid_b1", '0);
        applyStimulus(1'b1);
        loadBytes(8'h85, 16, 8'h33, 1'b0);
        expectValue("write_invalid_ignored", packRegs());
        applyStimulus(1'b0);
        popCheck(regs);

        // 32-byte write starting at reg0
        loadBytes(8'h80, 32, 8'h40, 1'b1);
        m_regs[0] = seqWord(8'h40);
`ifdef ASCON_SPI_BURST_EN
        m_regs[1] = seqWord(8'h50);
`endif
        expectValue("burst_write_reg0", packRegs());
        applyStimulus(1'b0);
        popCheck(regs);

        // 32-byte write at the last data register must not spill past it
        loadBytes(8'h82, 32, 8'hC0, 1'b1);
        m_regs[2] = seqWord(8'hC0);
        expectValue("write_last_reg", packRegs());
        applyStimulus(1'b0);
        popCheck(regs);

        // Reset in the middle of an S2 read while MISO is driving a one
        csb = 1'b0;
        #100;
        tx_bytes.delete();
        tx_bytes.push_back(8'h22);
        tx_bytes.push_back(8'h00);
        for (int n = 0; n < 9; n++) begin
            mosi = tx_bytes[n / 8][7 - (n % 8)];
            #50; sck = 1'b1;
            #50; sck = 1'b0;
        end
        #50;
        expectValue("miso_mid_read", RW'(1'b1));
        popCheck(RW'(miso));
        rst = 1'b1;
        #20;
        for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
        expectValue("rst_miso", '0);          popCheck(RW'(miso));
        expectValue("rst_miso_oe", '0);       popCheck(RW'(miso_oe));
        expectValue("rst_fsm_idle", RW'(ST_IDLE)); popCheck(RW'(dut.state));
        expectValue("rst_regs", packRegs());  popCheck(regs);
        csb = 1'b1;
        mosi = 1'b0;
        #100;
        rst = 1'b0;
        #100;
        loadBytes(8'h22, 8, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) expectValue($sformatf("post_rst_s2_b%0d", i), RW'(s[2][63-8*i -: 8]));
        applyStimulus(1'b1);

        checkOutput("scoreboard_drained", RW'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
